// File: rtl/inst_mem_loader_if.sv
// inst_mem_loader_if: byte-stream input, memory write port and status lines of the program loader
interface inst_mem_loader_if #(parameter int DW = 32);
  logic          start_i;
  logic          in_valid_i;
  logic [7:0]    in_data_i;
  logic          in_ready_o;
  logic          we_o;
  logic [DW-1:0] waddr_o;
  logic [DW-1:0] wdata_o;
  logic          core_hold_o;
  logic          busy_o;
  logic          done_o;
  logic          err_o;
  logic [15:0]   words_loaded_o;
  modport master (
    output start_i, in_valid_i, in_data_i,
    input  in_ready_o, we_o, waddr_o, wdata_o, core_hold_o, busy_o, done_o, err_o, words_loaded_o
  );
  modport slave (
    input  start_i, in_valid_i, in_data_i,
    output in_ready_o, we_o, waddr_o, wdata_o, core_hold_o, busy_o, done_o, err_o, words_loaded_o
  );
endinterface

// File: rtl/inst_mem_loader.sv
// inst_mem_loader: writes a length-prefixed little-endian byte stream into instruction memory, holding the core in reset meanwhile
module inst_mem_loader #(
  parameter int DW             = 32,
  parameter int MEM_SIZE_IN_KB = 1,
  parameter int NO_OF_REGS     = MEM_SIZE_IN_KB*1024/4,
  parameter int AW             = $clog2(NO_OF_REGS)
) (
  input logic           clk_i,
  input logic           rst_i,
  inst_mem_loader_if.slave bus
);
  typedef enum logic [2:0] {IDLE, LEN_LO, LEN_HI, DATA, WRITE, DONE, ERR} state_t;
  localparam logic [16:0] MAX_N = 17'(NO_OF_REGS);
  state_t        r_state, w_next;
  logic [15:0]   r_len, r_words, w_len_full;
  logic [1:0]    r_byte_cnt;
  logic [23:0]   r_buf;
  logic [DW-1:0] r_waddr, r_wdata;
  logic          w_acc, w_restart;
  assign bus.in_ready_o     = r_state inside {LEN_LO, LEN_HI, DATA};
  assign bus.we_o           = r_state == WRITE;
  assign bus.core_hold_o    = r_state != DONE;
  assign bus.busy_o         = r_state inside {LEN_LO, LEN_HI, DATA, WRITE};
  assign bus.done_o         = r_state == DONE;
  assign bus.err_o          = r_state == ERR;
  assign bus.waddr_o        = r_waddr;
  assign bus.wdata_o        = r_wdata;
  assign bus.words_loaded_o = r_words;
  assign w_acc      = bus.in_valid_i && bus.in_ready_o;
  assign w_restart  = bus.start_i && (r_state inside {IDLE, DONE, ERR});
  assign w_len_full = {bus.in_data_i, r_len[7:0]};
  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE, DONE, ERR: w_next = w_restart ? LEN_LO : r_state;
      LEN_LO:          w_next = w_acc ? LEN_HI : LEN_LO;
      LEN_HI:          w_next = !w_acc ? LEN_HI : (w_len_full == 16'd0) ? DONE : ({1'b0, w_len_full} > MAX_N) ? ERR : DATA;
      DATA:            w_next = (w_acc && r_byte_cnt == 2'd3) ? WRITE : DATA;
      WRITE:           w_next = (r_words + 16'd1 == r_len) ? DONE : DATA;
      default:         w_next = IDLE;
    endcase
  end
  always_ff @(posedge clk_i) begin
    if (!rst_i) begin
      r_state    <= IDLE;
      r_len      <= '0;
      r_words    <= '0;
      r_byte_cnt <= '0;
      r_buf      <= '0;
      r_waddr    <= '0;
      r_wdata    <= '0;
    end else begin
      r_state <= w_next;
      if (w_restart) begin
        r_words    <= '0;
        r_byte_cnt <= '0;
      end
      if (w_acc && r_state == LEN_LO) r_len[7:0] <= bus.in_data_i;
      if (w_acc && r_state == LEN_HI) r_len[15:8] <= bus.in_data_i;
      if (w_acc && r_state == DATA) begin
        r_byte_cnt <= r_byte_cnt + 2'd1;
        if (r_byte_cnt == 2'd3) begin
          r_wdata <= {bus.in_data_i, r_buf};
          r_waddr <= DW'({r_words[AW-1:0], 2'b00});
        end else begin
          r_buf[{r_byte_cnt, 3'b000} +: 8] <= bus.in_data_i;
        end
      end
      if (r_state == WRITE) r_words <= r_words + 16'd1;
    end
  end
endmodule

// File: tb/tb_inst_mem_loader.sv
// tb_inst_mem_loader: directed and randomized load sessions checked against a word-list reference model
module tb_inst_mem_loader;
  logic        clk = 0, rst = 0;
  int          cyc = 0, n_cmp = 0, n_bad = 0, last4 = -1;
  bit          noise = 0;
  logic [31:0] wq[$];
  logic [63:0] obs[$];
  inst_mem_loader_if #(.DW(32)) bus();
  inst_mem_loader dut (.clk_i(clk), .rst_i(rst), .bus(bus));
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask
  always @(negedge clk)
    if (rst && bus.we_o) begin
      obs.push_back({bus.waddr_o, bus.wdata_o});
      chk("we_latency", 64'(cyc), 64'(last4));
    end
  task automatic send_byte(input logic [7:0] b, input int gap, input bit last);
    bit acc;
    int t;
    repeat (gap) begin
      bus.start_i = noise ? 1'($urandom_range(0, 1)) : 1'b0;
      @(posedge clk);
      #1;
    end
    bus.start_i    = 0;
    bus.in_valid_i = 1;
    bus.in_data_i  = b;
    acc = 0;
    t   = 0;
    while (!acc && t < 50) begin
      @(negedge clk);
      acc = bus.in_ready_o;
      t++;
    end
    chk("byte_accepted", 64'(acc), 64'd1);
    @(posedge clk);
    #1;
    if (last) last4 = cyc;
    bus.in_valid_i = 0;
    bus.in_data_i  = 8'($urandom);
  endtask
  task automatic start_pulse();
    bus.start_i = 1;
    @(posedge clk);
    #1;
    bus.start_i = 0;
  endtask
  task automatic load(input int n, input int lo, input int hi);
    int          nw, t;
    bit          bad;
    logic [31:0] w;
    obs.delete();
    start_pulse();
    send_byte(n[7:0], 0, 0);
    send_byte(n[15:8], $urandom_range(lo, hi), 0);
    bad = n > 256;
    nw  = (bad || n == 0) ? 0 : n;
    for (int i = 0; i < nw; i++) begin
      w = wq[i];
      for (int k = 0; k < 4; k++) send_byte(w[8*k +: 8], $urandom_range(lo, hi), k == 3);
    end
    t = 0;
    while (!(bus.done_o || bus.err_o) && t < 20) begin
      @(negedge clk);
      t++;
    end
    chk("done", 64'(bus.done_o), 64'(!bad));
    chk("err", 64'(bus.err_o), 64'(bad));
    chk("core_hold", 64'(bus.core_hold_o), 64'(bad));
    chk("busy_end", 64'(bus.busy_o), 64'd0);
    chk("ready_end", 64'(bus.in_ready_o), 64'd0);
    chk("words_loaded", 64'(bus.words_loaded_o), 64'(nw));
    chk("n_writes", 64'(obs.size()), 64'(nw));
    for (int i = 0; i < obs.size() && i < nw; i++) chk("write", obs[i], {32'(i*4), wq[i]});
    @(posedge clk);
    #1;
  endtask
  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end
  initial begin
    int n;
    bus.start_i    = 1;
    bus.in_valid_i = 1;
    bus.in_data_i  = 8'hAA;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_ready", 64'(bus.in_ready_o), 64'd0);
    chk("rst_we", 64'(bus.we_o), 64'd0);
    chk("rst_waddr", 64'(bus.waddr_o), 64'd0);
    chk("rst_wdata", 64'(bus.wdata_o), 64'd0);
    chk("rst_core_hold", 64'(bus.core_hold_o), 64'd1);
    chk("rst_busy", 64'(bus.busy_o), 64'd0);
    chk("rst_done", 64'(bus.done_o), 64'd0);
    chk("rst_err", 64'(bus.err_o), 64'd0);
    chk("rst_words", 64'(bus.words_loaded_o), 64'd0);
    bus.start_i    = 0;
    bus.in_valid_i = 0;
    rst            = 1;
    @(posedge clk);
    #1;
    wq = '{32'h00A00513, 32'h00B00593};
    load(2, 0, 0);
    load(2, 3, 3);
    wq.delete();
    load(0, 0, 0);
    load(257, 0, 0);
    wq = '{32'hEFBEADDE};
    load(1, 0, 0);
    obs.delete();
    start_pulse();
    send_byte(8'h02, 0, 0);
    send_byte(8'h00, 0, 0);
    send_byte(8'h55, 0, 0);
    send_byte(8'h66, 0, 0);
    rst = 0;
    @(posedge clk);
    #1;
    rst = 1;
    chk("abort_busy", 64'(bus.busy_o), 64'd0);
    chk("abort_hold", 64'(bus.core_hold_o), 64'd1);
    chk("abort_words", 64'(bus.words_loaded_o), 64'd0);
    repeat (3) @(posedge clk);
    #1;
    chk("abort_no_write", 64'(obs.size()), 64'd0);
    wq = '{32'h44332211};
    load(1, 0, 0);
    noise = 1;
    repeat (6) begin
      n = $urandom_range(1, 6);
      wq.delete();
      for (int i = 0; i < n; i++) wq.push_back($urandom);
      load(n, 0, $urandom_range(0, 3));
    end
    noise = 0;
    wq.delete();
    for (int i = 0; i < 256; i++) wq.push_back($urandom);
    load(256, 0, 0);
    chk("last_waddr", 64'(bus.waddr_o), 64'h3FC);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule

// File: doc/inst_mem_loader.md
Name: inst_mem_loader

Overview:
Program loader that writes a byte stream into the instruction memory's write port. It sits between a byte-stream source (host link / UART receiver) and the instruction memory, and holds the core in reset while loading. The stream is a 16-bit little-endian word count N followed by 4*N bytes, each word little-endian. After the last write it releases the core.

Parameters:
DW, 32, instruction/data word width (fixed at 32; 4 bytes per word)
MEM_SIZE_IN_KB, 1, instruction memory size in KB
NO_OF_REGS, MEM_SIZE_IN_KB*1024/4, instruction memory depth in words
AW, $clog2(NO_OF_REGS), word-index counter width

Ports:
clk_i  input  1  clock, all state on rising edge
rst_i  input  1  synchronous active-low reset
start_i  input  1  single-cycle pulse that begins a load session
in_valid_i  input  1  byte-stream valid
in_data_i  input  8  byte-stream data
in_ready_o  output  1  byte-stream ready; a byte is accepted on an edge where in_valid_i && in_ready_o
we_o  output  1  instruction memory write enable, one cycle per word
waddr_o  output  DW  byte address of the write (word_index*4), 4-byte aligned
wdata_o  output  DW  assembled instruction word
core_hold_o  output  1  high keeps the core in reset; low lets it run
busy_o  output  1  high from session start until DONE/ERR
done_o  output  1  level, high in DONE
err_o  output  1  level, high in ERR
words_loaded_o  output  16  count of words written in the current/last session

Behaviour:
- Reset (rst_i low at an edge): state IDLE; in_ready_o=0, we_o=0, waddr_o=0, wdata_o=0, core_hold_o=1, busy_o=0, done_o=0, err_o=0, words_loaded_o=0, byte counter=0, length register=0. Reset mid-session aborts it with no further writes.
- States: IDLE, LEN_LO, LEN_HI, DATA, WRITE, DONE, ERR.
- IDLE: core_hold_o=1. start_i -> LEN_LO, clear words_loaded_o/byte counter/address.
- LEN_LO: in_ready_o=1; the accepted byte goes to N[7:0] -> LEN_HI.
- LEN_HI: in_ready_o=1; the accepted byte goes to N[15:8]. If N==0 -> DONE. If N>NO_OF_REGS -> ERR (no writes). Else -> DATA.
- DATA: in_ready_o=1; the accepted byte k (k=0..3) goes to wdata[8k+7:8k]. The 4th accepted byte -> WRITE. Stalls indefinitely while in_valid_i=0.
- WRITE: one cycle; in_ready_o=0, we_o=1, waddr_o=index*4, wdata_o=assembled word. On exit, index+1 and words_loaded_o+1. If words_loaded_o (after increment)==N -> DONE, else -> DATA.
- Latency: if the 4th byte is accepted at edge t, we_o is high in the cycle after t. The next byte is accepted no earlier than edge t+2. Peak rate is 1 word per 5 cycles.
- we_o is high only in WRITE; waddr_o/wdata_o hold their last values otherwise.
- DONE: core_hold_o=0, done_o=1, busy_o=0, in_ready_o=0. start_i -> LEN_LO (core_hold_o=1 again from the next cycle).
- ERR: core_hold_o=1, err_o=1, in_ready_o=0. Only start_i or reset leaves ERR; start_i -> LEN_LO.
- busy_o=1 in LEN_LO, LEN_HI, DATA, WRITE. start_i is ignored while busy_o=1.
- in_valid_i is ignored when in_ready_o=0; no byte is consumed in IDLE, WRITE, DONE or ERR.
- Boundary: N==NO_OF_REGS is legal; the last write is at waddr_o=(NO_OF_REGS-1)*4 and the index never wraps.
- Simultaneous rst_i low and start_i: reset wins.

Test Plan:
- Reset: hold rst_i low 2 cycles with start_i=1 -> IDLE, all outputs at reset values, core_hold_o=1, no we_o.
- Basic load: start_i, then bytes 02 00 | 13 05 A0 00 | 93 05 B0 00 back-to-back -> we_o pulses: (waddr 0x0, wdata 0x00A00513), (waddr 0x4, wdata 0x00B00593). Each pulse is one cycle after its 4th byte. Then done_o=1, core_hold_o=0, words_loaded_o=2.
- Throttled source: same stream with in_valid_i low 3 cycles between every byte -> identical writes and final state, no spurious we_o.
- Zero length: start_i, bytes 00 00 -> DONE directly, no we_o, words_loaded_o=0.
- Overflow: default params, length bytes 01 01 (N=257 > 256) -> err_o=1, no we_o, in_ready_o=0, core_hold_o=1. Then start_i with N=1 and word DE AD BE EF -> write wdata 0xEFBEADDE at 0x0, done_o=1.
- Abort: reset after 2 of 4 data bytes of word 1, then restart with N=1 and 11 22 33 44 -> single write 0x44332211 at 0x0, no stale bytes.
